// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    // Parity mode encoding matches the integer PARITY generic (0/1/2).
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    // Samples within one bit period that feed the majority vote.
    localparam logic [3:0] SAMPLE_A = 4'd7;
    localparam logic [3:0] SAMPLE_B = 4'd8;
    localparam logic [3:0] SAMPLE_C = 4'd9;

    // Clocks per 16x oversample tick, rounded to nearest.
    function automatic int osr_div(input int clk_mhz, input int bit_rate);
        longint num;
        longint den;
        num = longint'(clk_mhz) * 64'sd1000000;
        den = longint'(bit_rate) * 64'sd16;
        return int'((num + den / 2) / den);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; the head word reads as zero
// while empty so the stream outputs have a defined value out of reset.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Status flags, accepted push/pop and next pointer values.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push  = push && (!full || do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array written on accepted pushes.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; empty-gating of pop_data hides stale contents.
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: 2-flop synchronizer, 16x oversampling with 3-sample
// majority vote, optional parity, 1 or 2 stop bits, output FIFO.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50,
    parameter int BIT_RATE   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overflow,
    output logic                 busy
);

    localparam int               OSR_DIV  = osr_div(CLK_FREQ, BIT_RATE);
    localparam int               DIV_W    = $clog2(OSR_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OSR_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam int               BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};
    localparam parity_t          PAR_MODE = parity_t'(PARITY);
    localparam int               WORD_W   = DATA_BITS + 2;

    logic                 rx_meta_q, rx_sync_q;
    rx_state_t            state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [3:0]           sample_q, sample_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 s7_q, s7_d;
    logic                 s8_q, s8_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 armed_q, armed_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;

    logic                 tick;
    logic                 decide;
    logic                 bit_val;
    logic                 last_stop;
    logic                 push;
    logic [WORD_W-1:0]    push_word;
    logic                 pop;
    logic [WORD_W-1:0]    fifo_word;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Two-flop synchronizer; idles high so reset cannot fake a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Next-state logic: oversample divider, sample counter, bit decisions.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        sample_d     = sample_q;
        bit_d        = bit_q;
        stop_cnt_d   = stop_cnt_q;
        s7_d         = s7_q;
        s8_d         = s8_q;
        shift_d      = shift_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        armed_d      = armed_q;
        push         = 1'b0;
        push_word    = {shift_q, parity_err_q, frame_err_q};

        tick      = (state_q != S_IDLE) && (div_q == DIV_LAST);
        decide    = tick && (sample_q == SAMPLE_C);
        bit_val   = majority3(s7_q, s8_q, rx_sync_q);
        last_stop = (STOP_BITS == 1) || stop_cnt_q;

        if (state_q != S_IDLE) begin
            div_d = tick ? '0 : div_q + DIV_ONE;
            if (tick) begin
                sample_d = sample_q + 4'd1;
                if (sample_q == SAMPLE_A) s7_d = rx_sync_q;
                if (sample_q == SAMPLE_B) s8_d = rx_sync_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                // Re-arm only once the line has been seen high after a frame.
                armed_d      = armed_q | rx_sync_q;
                div_d        = '0;
                sample_d     = '0;
                bit_d        = '0;
                stop_cnt_d   = 1'b0;
                parity_err_d = 1'b0;
                frame_err_d  = 1'b0;
                if (armed_q && !rx_sync_q) begin
                    state_d = S_START;
                    armed_d = 1'b0;
                end
            end
            S_START: begin
                if (decide) state_d = bit_val ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = (PAR_MODE == PAR_NONE) ? S_STOP : S_PARITY;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    parity_err_d = bit_val ^ (^shift_q) ^ (PAR_MODE == PAR_ODD);
                    state_d      = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    frame_err_d = frame_err_q | ~bit_val;
                    if (last_stop) begin
                        push      = 1'b1;
                        push_word = {shift_q, parity_err_q, frame_err_d};
                        state_d   = S_IDLE;
                        armed_d   = 1'b0;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        overflow_d = push && fifo_full && !pop;
    end

    // Receiver state and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            sample_q     <= '0;
            bit_q        <= '0;
            stop_cnt_q   <= 1'b0;
            s7_q         <= 1'b1;
            s8_q         <= 1'b1;
            shift_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            armed_q      <= 1'b1;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            sample_q     <= sample_d;
            bit_q        <= bit_d;
            stop_cnt_q   <= stop_cnt_d;
            s7_q         <= s7_d;
            s8_q         <= s8_d;
            shift_q      <= shift_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            armed_q      <= armed_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (fifo_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_valid  = ~fifo_empty;
    assign pop      = m_valid & m_ready;
    assign {m_data, m_parity_err, m_frame_err} = fifo_word;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: instance A is 8N1, instance B is 8 data, even parity,
// 2 stop bits. Stimulus pushes expected words; monitors pop and compare.
module tb_uart_rx_param;

    localparam int OSR      = 27;
    localparam int BIT_CLKS = 16 * OSR;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } word_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_a, rx_b;
    logic       m_ready_a, m_ready_b;
    logic [7:0] m_data_a, m_data_b;
    logic       m_parity_err_a, m_parity_err_b;
    logic       m_frame_err_a, m_frame_err_b;
    logic       m_valid_a, m_valid_b;
    logic       overflow_a, overflow_b;
    logic       busy_a, busy_b;

    word_t exp_a[$];
    word_t exp_b[$];
    word_t w_a, w_b;
    int    checks = 0;
    int    errors = 0;
    int    ov_a   = 0;
    int    ov_b   = 0;

    always #10 clk = ~clk;

    uart_rx_param u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx_a),
        .m_data       (m_data_a),
        .m_parity_err (m_parity_err_a),
        .m_frame_err  (m_frame_err_a),
        .m_valid      (m_valid_a),
        .m_ready      (m_ready_a),
        .overflow     (overflow_a),
        .busy         (busy_a)
    );

    uart_rx_param #(
        .PARITY    (2),
        .STOP_BITS (2)
    ) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx_b),
        .m_data       (m_data_b),
        .m_parity_err (m_parity_err_b),
        .m_frame_err  (m_frame_err_b),
        .m_valid      (m_valid_b),
        .m_ready      (m_ready_b),
        .overflow     (overflow_b),
        .busy         (busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor A: compare every accepted word against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (overflow_a) ov_a++;
            if (m_valid_a && m_ready_a) begin
                if (exp_a.size() == 0) begin
                    check("a_unexpected_word", {24'd0, m_data_a}, 32'hFFFF_FFFF);
                end else begin
                    w_a = exp_a.pop_front();
                    check("a_data", {24'd0, m_data_a}, {24'd0, w_a.data});
                    check("a_parity_err", {31'd0, m_parity_err_a}, {31'd0, w_a.perr});
                    check("a_frame_err", {31'd0, m_frame_err_a}, {31'd0, w_a.ferr});
                end
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (!reset) begin
            if (overflow_b) ov_b++;
            if (m_valid_b && m_ready_b) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected_word", {24'd0, m_data_b}, 32'hFFFF_FFFF);
                end else begin
                    w_b = exp_b.pop_front();
                    check("b_data", {24'd0, m_data_b}, {24'd0, w_b.data});
                    check("b_parity_err", {31'd0, m_parity_err_b}, {31'd0, w_b.perr});
                    check("b_frame_err", {31'd0, m_frame_err_b}, {31'd0, w_b.ferr});
                end
            end
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive n line bits LSB first, one bit time each.
    task automatic drive(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rx_a = bits[i];
            else          rx_b = bits[i];
            clk_wait(BIT_CLKS);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop);
        drive(0, {6'd0, stop, d, 1'b0}, 10);
    endtask

    task automatic send_b(input logic [7:0] d, input logic par, input logic stop1, input logic stop2);
        drive(1, {4'd0, stop2, stop1, par, d, 1'b0}, 12);
    endtask

    task automatic wait_empty(input int sel, input string name);
        int n;
        n = 0;
        while (((sel == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 2 * BIT_CLKS) begin
            clk_wait(1);
            n++;
        end
        check(name, (sel == 0) ? exp_a.size() : exp_b.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        rx_a      = 1'b1;
        rx_b      = 1'b1;
        m_ready_a = 1'b1;
        m_ready_b = 1'b1;
        clk_wait(5);
        check("rst_m_valid", {31'd0, m_valid_a}, 0);
        check("rst_m_data", {24'd0, m_data_a}, 0);
        check("rst_m_parity_err", {31'd0, m_parity_err_a}, 0);
        check("rst_m_frame_err", {31'd0, m_frame_err_a}, 0);
        check("rst_overflow", {31'd0, overflow_a}, 0);
        check("rst_busy", {31'd0, busy_a}, 0);
        check("rst_b_m_valid", {31'd0, m_valid_b}, 0);
        reset = 1'b0;
        clk_wait(2);

        fork
            begin
                // Clean 8N1 word.
                exp_a.push_back('{8'h5A, 1'b0, 1'b0});
                send_a(8'h5A, 1'b1);
                drive(0, 16'hFFFF, 1);
                wait_empty(0, "a_5a_drain");

                // Stop bit low followed by a break, then a clean word.
                exp_a.push_back('{8'hA5, 1'b0, 1'b1});
                send_a(8'hA5, 1'b0);
                drive(0, 16'h0000, 1);
                drive(0, 16'hFFFF, 2);
                exp_a.push_back('{8'h3C, 1'b0, 1'b0});
                send_a(8'h3C, 1'b1);
                drive(0, 16'hFFFF, 1);
                wait_empty(0, "a_3c_drain");

                // 5-tick glitch is rejected within one bit time.
                rx_a = 1'b0;
                clk_wait(10);
                check("glitch_busy_high", {31'd0, busy_a}, 1);
                clk_wait(5 * OSR - 10);
                rx_a = 1'b1;
                clk_wait(BIT_CLKS - 5 * OSR);
                check("glitch_busy_low", {31'd0, busy_a}, 0);
                check("glitch_no_word", {31'd0, m_valid_a}, 0);

                // 10-tick low pulse is a valid start; line high gives 0xFF.
                exp_a.push_back('{8'hFF, 1'b0, 1'b0});
                rx_a = 1'b0;
                clk_wait(10 * OSR);
                rx_a = 1'b1;
                clk_wait(30);
                check("pulse10_busy", {31'd0, busy_a}, 1);
                clk_wait(11 * BIT_CLKS);
                wait_empty(0, "a_pulse10_drain");
            end
            begin
                // 0x37 has five ones: even parity bit is 1.
                exp_b.push_back('{8'h37, 1'b1, 1'b0});
                send_b(8'h37, 1'b0, 1'b1, 1'b1);
                drive(1, 16'hFFFF, 1);
                exp_b.push_back('{8'h37, 1'b0, 1'b0});
                send_b(8'h37, 1'b1, 1'b1, 1'b1);
                drive(1, 16'hFFFF, 1);
                // Second stop bit low.
                exp_b.push_back('{8'h37, 1'b0, 1'b1});
                send_b(8'h37, 1'b1, 1'b1, 1'b0);
                drive(1, 16'hFFFF, 2);
                // 0x00: even parity bit is 0.
                exp_b.push_back('{8'h00, 1'b0, 1'b0});
                send_b(8'h00, 1'b0, 1'b1, 1'b1);
                drive(1, 16'hFFFF, 1);
                wait_empty(1, "b_drain");
            end
        join

        // FIFO fill with consumer stalled: 5th word overflows.
        m_ready_a = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_a.push_back('{k[7:0], 1'b0, 1'b0});
            send_a(k[7:0], 1'b1);
            drive(0, 16'hFFFF, 1);
            if (k == 4) check("ovf_before_5th", ov_a, 0);
        end
        check("ovf_at_5th", ov_a, 1);
        check("held_valid", {31'd0, m_valid_a}, 1);
        check("held_data", {24'd0, m_data_a}, 32'h01);
        m_ready_a = 1'b1;
        wait_empty(0, "a_fifo_drain");

        // Reset during data bit 3 of 0xC3 abandons the frame.
        drive(0, {6'd0, 1'b1, 8'hC3, 1'b0}, 4);
        rx_a = 1'b0;
        clk_wait(BIT_CLKS / 2);
        reset = 1'b1;
        rx_a  = 1'b1;
        clk_wait(4);
        reset = 1'b0;
        clk_wait(1);
        check("post_rst_busy", {31'd0, busy_a}, 0);
        check("post_rst_valid", {31'd0, m_valid_a}, 0);
        clk_wait(BIT_CLKS);
        check("post_rst_no_word", {31'd0, m_valid_a}, 0);
        exp_a.push_back('{8'h81, 1'b0, 1'b0});
        send_a(8'h81, 1'b1);
        drive(0, 16'hFFFF, 1);
        wait_empty(0, "a_81_drain");

        check("total_ovf_a", ov_a, 1);
        check("total_ovf_b", ov_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog bounds the run if a wait never completes.
    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
